// File: rtl/noc_packet_transmitter.sv
// Endpoint packetizer: turns a packet request plus a payload beat stream into
// a header flit followed by payload flits on a valid/ready flit channel.
// The output flit is held in a single register stage that can reload on the
// same cycle it is accepted, so continuous flow sustains one flit per cycle.
module noc_packet_transmitter #(
    parameter int unsigned X_WIDTH     = 3,
    parameter int unsigned Y_WIDTH     = 3,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MAX_PAYLOAD = 8,
    parameter int unsigned X           = 0,
    parameter int unsigned Y           = 0,
    localparam int unsigned LEN_WIDTH  = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [X_WIDTH-1:0]    req_dest_x,
    input  logic [Y_WIDTH-1:0]    req_dest_y,
    input  logic [LEN_WIDTH-1:0]  req_length,
    input  logic                  payload_valid,
    output logic                  payload_ready,
    input  logic [DATA_WIDTH-1:0] payload_data,
    output logic                  flit_valid,
    input  logic                  flit_ready,
    output logic                  flit_type,
    output logic                  flit_tail,
    output logic [DATA_WIDTH-1:0] flit_data,
    output logic                  busy
);

    localparam int unsigned HDR_WIDTH = 2 * X_WIDTH + 2 * Y_WIDTH + LEN_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
        StPayload
    } state_e;

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  remain_q, remain_d;
    logic                  flit_valid_q, flit_valid_d;
    logic                  flit_type_q, flit_type_d;
    logic                  flit_tail_q, flit_tail_d;
    logic [DATA_WIDTH-1:0] flit_data_q, flit_data_d;

    logic                  req_fire;
    logic                  payload_fire;
    logic                  flit_accept;
    logic                  out_free;
    logic [LEN_WIDTH-1:0]  len_clamped;
    logic [DATA_WIDTH-1:0] header_flit;

    // Handshake decode; payload_ready looks through to flit_ready so the
    // output register can be refilled in the cycle it drains.
    always_comb begin
        flit_accept   = flit_valid_q && flit_ready;
        out_free      = !flit_valid_q || flit_ready;
        req_ready     = (state_q == StIdle);
        busy          = (state_q != StIdle);
        payload_ready = (state_q != StIdle) && (remain_q != '0) && out_free;
        req_fire      = req_valid && req_ready;
        payload_fire  = payload_valid && payload_ready;
    end

    // Clamp the requested length and assemble the header flit, LSB first:
    // dest_x, dest_y, src_x, src_y, length; upper bits zero.
    always_comb begin
        len_clamped = req_length;
        if (req_length > LEN_WIDTH'(MAX_PAYLOAD)) begin
            len_clamped = LEN_WIDTH'(MAX_PAYLOAD);
        end
        header_flit = '0;
        header_flit[HDR_WIDTH-1:0] = {len_clamped, Y_WIDTH'(Y), X_WIDTH'(X),
                                      req_dest_y, req_dest_x};
    end

    // Next state, remaining-beat counter and output register loads.
    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        flit_valid_d = flit_valid_q;
        flit_type_d  = flit_type_q;
        flit_tail_d  = flit_tail_q;
        flit_data_d  = flit_data_q;

        // Accepted flit with nothing new behind it leaves a bubble.
        if (flit_accept) begin
            flit_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (req_fire) begin
                    state_d      = StHeader;
                    remain_d     = len_clamped;
                    flit_valid_d = 1'b1;
                    flit_type_d  = 1'b1;
                    flit_tail_d  = (len_clamped == '0);
                    flit_data_d  = header_flit;
                end
            end
            StHeader: begin
                if (flit_accept) begin
                    state_d = (remain_q == '0) ? StIdle : StPayload;
                end
            end
            StPayload: begin
                if (flit_accept && flit_tail_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Only reachable outside StIdle, so never collides with a header load.
        if (payload_fire) begin
            flit_valid_d = 1'b1;
            flit_type_d  = 1'b0;
            flit_tail_d  = (remain_q == LEN_WIDTH'(1));
            flit_data_d  = payload_data;
            remain_d     = remain_q - LEN_WIDTH'(1);
        end
    end

    // State and output registers; reset drops any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            remain_q     <= '0;
            flit_valid_q <= 1'b0;
            flit_type_q  <= 1'b0;
            flit_tail_q  <= 1'b0;
            flit_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            flit_valid_q <= flit_valid_d;
            flit_type_q  <= flit_type_d;
            flit_tail_q  <= flit_tail_d;
            flit_data_q  <= flit_data_d;
        end
    end

    assign flit_valid = flit_valid_q;
    assign flit_type  = flit_type_q;
    assign flit_tail  = flit_tail_q;
    assign flit_data  = flit_data_q;

endmodule

// File: doc/noc_packet_transmitter.md
# noc_packet_transmitter

Endpoint-side packetizer that drives a router's local input port. Accepts a packet request (destination coordinates and payload length) plus a payload beat stream, and emits a header flit followed by payload flits over a valid/ready flit channel, marking the last flit as tail. It is the injecting end of the flit protocol that the router's local output delivers to a receiving endpoint. A registered output stage sustains one flit per cycle under continuous flow.

## Interface
- X_WIDTH, 3: width of an X coordinate
- Y_WIDTH, 3: width of a Y coordinate
- DATA_WIDTH, 32: flit data width; must be ≥ 2*X_WIDTH + 2*Y_WIDTH + LEN_WIDTH
- MAX_PAYLOAD, 8: maximum payload flits per packet
- X, 0: this node's X coordinate, placed in the header source field
- Y, 0: this node's Y coordinate, placed in the header source field
- LEN_WIDTH (derived): $clog2(MAX_PAYLOAD+1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  packet request valid
- req_ready  out  1  request accepted when both high
- req_dest_x  in  X_WIDTH  destination X
- req_dest_y  in  Y_WIDTH  destination Y
- req_length  in  LEN_WIDTH  payload flit count (0 allowed)
- payload_valid  in  1  payload beat valid
- payload_ready  out  1  payload beat accepted when both high
- payload_data  in  DATA_WIDTH  payload beat
- flit_valid  out  1  output flit valid
- flit_ready  in  1  downstream accepts flit
- flit_type  out  1  1 = header, 0 = payload
- flit_tail  out  1  last flit of packet
- flit_data  out  DATA_WIDTH  flit contents
- busy  out  1  packet in progress

## Operation
- FSM states: IDLE, HEADER, PAYLOAD. req_ready = (state==IDLE). busy = (state!=IDLE).
- IDLE: on req_valid&&req_ready, latch fields and load the output register with the header flit. Set flit_valid=1, flit_type=1, flit_tail=(length==0). Load remain counter = length. Go to HEADER.
- Length clamp: a req_length above MAX_PAYLOAD is clamped to MAX_PAYLOAD at acceptance. The header carries the clamped value.
- Header flit_data layout, LSB first: dest_x, dest_y, src_x(X), src_y(Y), length. Remaining upper bits are 0.
- payload_ready = (state∈{HEADER,PAYLOAD}) && remain!=0 && (!flit_valid || flit_ready). This is combinational on flit_ready.
- On payload_valid&&payload_ready:
  - Load the output register with flit_type=0, flit_data=payload_data, flit_tail=(remain==1), flit_valid=1.
  - Decrement remain.
- HEADER, on header accept:
  - length==0 → IDLE.
  - Otherwise → PAYLOAD. A payload beat may load in the same cycle.
- PAYLOAD, on accept of the tail flit → IDLE.
- On any accept with no new load, flit_valid clears.
- Once asserted, flit_valid stays high and flit_type/tail/data stay stable until flit_ready.
- payload_data is ignored whenever payload_ready=0. A destination equal to (X,Y) gets no special handling.

## Timing
- Reset values (asynchronous): state IDLE, flit_valid=0, flit_type=0, flit_tail=0, flit_data=0, remain=0. Hence req_ready=1, payload_ready=0, busy=0.
- Request accepted at edge n → header flit valid from cycle n+1.
- With flit_ready=1 and payload_valid=1 throughout, a packet of length L emits L+1 flits on consecutive cycles n+1…n+L+1.
- Tail accepted at edge m → IDLE in cycle m+1. The next request can be accepted at edge m+1, and its header appears at m+2. This gives one idle cycle between packets.
- Payload starvation (payload_valid=0) yields bubbles: flit_valid=0 after drain, with state held in PAYLOAD.
- Reset asserted mid-packet drops the packet immediately. There is no partial tail.

## Test plan
- Reset: assert rst_n=0 mid-sim → within the same cycle flit_valid=0, req_ready=1, payload_ready=0, busy=0, flit_data=0.
- Zero length: X=1, Y=2; request dest(3,0) len 0 → next cycle one flit with type=1, tail=1, data=0x443. busy falls after accept.
- Streaming: len 3; payloads 0xA,0xB,0xC back-to-back; flit_ready=1 → header, 0xA, 0xB, 0xC(tail) on 4 consecutive cycles. A second request is accepted the cycle after the tail drains.
- Backpressure: len 4; drop flit_ready for 5 cycles while payload flit 0xB is valid → flit 0xB stays stable, payload_ready=0, no beats lost or duplicated. Order is preserved after release.
- Clamp: MAX_PAYLOAD=8; request len 10 → header length field=8. Exactly 8 payload beats are consumed, and the 8th is tail.
- Reset mid-packet: assert reset after 2 of 5 payload flits → outputs return to reset values. The next request len 1 produces a correct header and a tail payload.
